// File: rtl/opc5_cpu_pkg.sv
// Shared definitions for the OPC5 core: FSM encodings, opcodes,
// predicate codes and the halt pattern.
package opc5_cpu_pkg;

    typedef enum logic [2:0] {
        FETCH0 = 3'b000,
        FETCH1 = 3'b001,
        EA_ED  = 3'b010,
        RDMEM  = 3'b011,
        EXEC   = 3'b100,
        WRMEM  = 3'b101
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_STO  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ROR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_SUB  = 4'hA;
    localparam logic [3:0] OP_SBC  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_CMPC = 4'hD;
    localparam logic [3:0] OP_BSWP = 4'hE;
    localparam logic [3:0] OP_PSR  = 4'hF;

    localparam logic [2:0] P_ALWAYS = 3'b000;
    localparam logic [2:0] P_NEVER  = 3'b001;
    localparam logic [2:0] P_Z      = 3'b010;
    localparam logic [2:0] P_NZ     = 3'b011;
    localparam logic [2:0] P_C      = 3'b100;
    localparam logic [2:0] P_NC     = 3'b101;
    localparam logic [2:0] P_S      = 3'b110;
    localparam logic [2:0] P_NS     = 3'b111;

    localparam logic [10:0] HALT_PAT = 11'h000;

    function automatic logic pred_ok(input logic [2:0] p,
                                     input logic c,
                                     input logic z,
                                     input logic s);
        logic ok;
        unique case (p)
            P_ALWAYS: ok = 1'b1;
            P_NEVER:  ok = 1'b0;
            P_Z:      ok = z;
            P_NZ:     ok = !z;
            P_C:      ok = c;
            P_NC:     ok = !c;
            P_S:      ok = s;
            default:  ok = !s;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/opc5_alu.sv
// OPC5 combinational ALU: result and C/Z/S from opcode, dst value,
// effective operand and carry in.
module opc5_alu
    import opc5_cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] result,
    output logic        cout,
    output logic        zout,
    output logic        sout
);

    logic [16:0] sum;

    always_comb begin
        sum    = 17'h0;
        result = b;
        cout   = cin;
        unique case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[15:0];
                cout   = sum[16];
            end
            OP_ADC: begin
                sum    = {1'b0, a} + {1'b0, b} + {16'h0, cin};
                result = sum[15:0];
                cout   = sum[16];
            end
            // carry out of a + ~b + 1 is the inverted borrow
            OP_SUB, OP_CMP: begin
                sum    = {1'b0, a} + {1'b0, ~b} + 17'd1;
                result = sum[15:0];
                cout   = sum[16];
            end
            OP_SBC, OP_CMPC: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {16'h0, cin};
                result = sum[15:0];
                cout   = sum[16];
            end
            OP_ROR: begin
                result = {cin, b[15:1]};
                cout   = b[0];
            end
            OP_NOT:  result = ~b;
            OP_BSWP: result = {b[7:0], b[15:8]};
            default: result = b;
        endcase
        zout = (result == 16'h0);
        sout = result[15];
    end

endmodule

// File: rtl/opc5_cpu.sv
// OPC5 16-bit CPU core with one multiplexed memory port.
// Define OPC5_HALT_EN to make the halt pattern freeze the core in EXEC.
module opc5_cpu
    import opc5_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_b,
    output logic [15:0] address,
    input  logic [15:0] datain,
    output logic [15:0] dataout,
    output logic        rnw
);

    state_t      state;
    logic [15:0] rf [0:15];
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] opr;
    logic [15:0] ea;
    logic        c, z, s;

    logic [3:0]  op, src, dst;
    logic [15:0] src_val, dst_val, alu_res, wdata;
    logic        alu_c, alu_z, alu_s;
    logic        is_halt, wr_en;

    assign op  = ir[11:8];
    assign src = ir[7:4];
    assign dst = ir[3:0];

    always_comb begin
        src_val = rf[src];
        dst_val = rf[dst];
        if (src == 4'd0)  src_val = 16'h0;
        if (src == 4'd15) src_val = pc;
        if (dst == 4'd0)  dst_val = 16'h0;
        if (dst == 4'd15) dst_val = pc;
    end

    opc5_alu u_alu (
        .op     (op),
        .a      (dst_val),
        .b      (ea),
        .cin    (c),
        .result (alu_res),
        .cout   (alu_c),
        .zout   (alu_z),
        .sout   (alu_s)
    );

    assign is_halt = (ir[10:0] == HALT_PAT);
    assign wr_en   = !(op == OP_STO || op == OP_CMP || op == OP_CMPC ||
                       (op == OP_PSR && dst == 4'd0));
    assign wdata   = (op == OP_PSR) ? {13'b0, c, z, s} : alu_res;

    // Reset gates the bus at once so an aborted WRMEM never commits.
    always_comb begin
        address = 16'h0;
        dataout = 16'h0;
        rnw     = 1'b1;
        if (!reset_b) begin
            address = (state == RDMEM || state == WRMEM) ? ea : pc;
            if (state == WRMEM) begin
                rnw     = 1'b0;
                dataout = dst_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state <= FETCH0;
            pc    <= 16'h0;
            ir    <= 16'h0;
            opr   <= 16'h0;
            ea    <= 16'h0;
            c     <= 1'b0;
            z     <= 1'b0;
            s     <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0;
        end else begin
            unique case (state)
                FETCH0: begin
                    ir    <= datain;
                    pc    <= pc + 16'd1;
                    state <= datain[12] ? FETCH1 : EA_ED;
                end
                FETCH1: begin
                    opr   <= datain;
                    pc    <= pc + 16'd1;
                    state <= EA_ED;
                end
                EA_ED: begin
                    ea <= src_val + (ir[12] ? opr : 16'h0);
                    if (!pred_ok(ir[15:13], c, z, s)) state <= FETCH0;
                    else if (op == OP_LD)             state <= RDMEM;
                    else if (op == OP_STO)            state <= WRMEM;
                    else                              state <= EXEC;
                end
                RDMEM: begin
                    ea    <= datain;
                    state <= EXEC;
                end
                EXEC: begin
                    if (!is_halt) begin
                        if (wr_en) begin
                            if (dst == 4'd15)     pc      <= wdata;
                            else if (dst != 4'd0) rf[dst] <= wdata;
                        end
                        if (op == OP_PSR) begin
                            if (dst == 4'd0) {c, z, s} <= ea[2:0];
                        end else begin
                            {c, z, s} <= {alu_c, alu_z, alu_s};
                        end
                        state <= FETCH0;
                    end else begin
`ifdef OPC5_HALT_EN
                        state <= EXEC;
`else
                        state <= FETCH0;
`endif
                    end
                end
                WRMEM:   state <= FETCH0;
                default: state <= FETCH0;
            endcase
        end
    end

endmodule

// File: tb/tb_opc5_cpu.sv
// Directed self-checking bench for opc5_cpu with a 1K-word memory model
// (program image plus a write-back overlay committed on falling edges).
module tb_opc5_cpu;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        clr = 1'b1;
    logic [15:0] address, datain, dataout;
    logic        rnw;

    logic [15:0] prog [0:1023];
    logic [15:0] dmem [0:1023];
    logic        dval [0:1023];
    int          wr_cnt, cyc, first_wr;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        found;

    opc5_cpu dut (
        .clk     (clk),
        .reset_b (reset_b),
        .address (address),
        .datain  (datain),
        .dataout (dataout),
        .rnw     (rnw)
    );

    always #5 clk = ~clk;

    assign datain = dval[address[9:0]] ? dmem[address[9:0]]
                                       : prog[address[9:0]];

    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) dval[i] <= 1'b0;
            wr_cnt   <= 0;
            cyc      <= 0;
            first_wr <= 0;
        end else begin
            if (!reset_b) cyc <= cyc + 1;
            if (!rnw) begin
                dmem[address[9:0]] <= dataout;
                dval[address[9:0]] <= 1'b1;
                wr_cnt <= wr_cnt + 1;
                if (first_wr == 0) first_wr <= cyc + 1;
            end
        end
    end

    function automatic logic [15:0] ins(input logic [2:0] p,
                                        input logic       l,
                                        input logic [3:0] o,
                                        input logic [3:0] sr,
                                        input logic [3:0] d);
        return {p, l, o, sr, d};
    endfunction

    function automatic logic [15:0] memv(input int a);
        return dval[a] ? dmem[a] : 16'h0;
    endfunction

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic begin_prog();
        clr     = 1'b1;
        reset_b = 1'b1;
        for (int i = 0; i < 1024; i++) prog[i] = 16'h0;
    endtask

    task automatic go(input int n);
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b0;
        clr     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // mov r1,#0x1234 ; halt ; psr r5 ; sto r1 ; sto r5 ; loop
        begin_prog();
        prog[0]  = ins(0, 1, 4'h0, 0, 1);  prog[1]  = 16'h1234;
        prog[2]  = 16'h0000;
        prog[3]  = ins(0, 0, 4'hF, 0, 5);
        prog[4]  = ins(0, 1, 4'h6, 0, 1);  prog[5]  = 16'h0200;
        prog[6]  = ins(0, 1, 4'h6, 0, 5);  prog[7]  = 16'h0201;
        prog[8]  = ins(0, 1, 4'h0, 0, 15); prog[9]  = 16'h0008;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", address, 16'h0);
        check("rst_rnw", 16'(rnw), 16'h1);
        check("rst_dout", dataout, 16'h0);
        go(40);
`ifdef OPC5_HALT_EN
        check("halt_addr", address, 16'h0003);
        check("halt_rnw", 16'(rnw), 16'h1);
        check("halt_nowr", 16'(wr_cnt), 16'h0);
`else
        check("mov_r1", memv(16'h200), 16'h1234);
        check("mov_flags", memv(16'h201), 16'h0000);
        check("halt_nop_t", 16'(first_wr), 16'd14);
        check("t1_writes", 16'(wr_cnt), 16'd2);
`endif

        // add sets C,Z ; adc picks up carry
        begin_prog();
        prog[0]  = ins(0, 1, 4'h0, 0, 1);  prog[1]  = 16'hFFFF;
        prog[2]  = ins(0, 1, 4'h4, 0, 1);  prog[3]  = 16'h0001;
        prog[4]  = ins(0, 0, 4'hF, 0, 5);
        prog[5]  = ins(0, 0, 4'h5, 0, 2);
        prog[6]  = ins(0, 1, 4'h6, 0, 1);  prog[7]  = 16'h0200;
        prog[8]  = ins(0, 1, 4'h6, 0, 5);  prog[9]  = 16'h0201;
        prog[10] = ins(0, 1, 4'h6, 0, 2);  prog[11] = 16'h0202;
        prog[12] = ins(0, 1, 4'h0, 0, 15); prog[13] = 16'h000C;
        go(60);
        check("add_r1", memv(16'h200), 16'h0000);
        check("add_flags", memv(16'h201), 16'h0006);
        check("adc_r2", memv(16'h202), 16'h0001);
        check("t2_writes", 16'(wr_cnt), 16'd3);

        // sto then ld back
        begin_prog();
        prog[0]  = ins(0, 1, 4'h0, 0, 1);  prog[1]  = 16'hBEEF;
        prog[2]  = ins(0, 1, 4'h6, 0, 1);  prog[3]  = 16'h0100;
        prog[4]  = ins(0, 1, 4'h7, 0, 3);  prog[5]  = 16'h0100;
        prog[6]  = ins(0, 0, 4'hF, 0, 5);
        prog[7]  = ins(0, 1, 4'h6, 0, 3);  prog[8]  = 16'h0200;
        prog[9]  = ins(0, 1, 4'h6, 0, 5);  prog[10] = 16'h0201;
        prog[11] = ins(0, 1, 4'h0, 0, 15); prog[12] = 16'h000B;
        go(60);
        check("sto_mem", memv(16'h100), 16'hBEEF);
        check("ld_r3", memv(16'h200), 16'hBEEF);
        check("ld_flags", memv(16'h201), 16'h0001);
        check("rnw_cycles", 16'(wr_cnt), 16'd3);

        // cmp + Z-predicated jump, taken and skipped
        for (int v = 5; v <= 6; v++) begin
            begin_prog();
            prog[0]    = ins(0, 1, 4'h0, 0, 1);  prog[1]    = 16'(v);
            prog[2]    = ins(0, 1, 4'hC, 0, 1);  prog[3]    = 16'h0005;
            prog[4]    = ins(2, 1, 4'h0, 0, 15); prog[5]    = 16'h0040;
            prog[6]    = ins(0, 1, 4'h6, 0, 1);  prog[7]    = 16'h0201;
            prog[8]    = ins(0, 1, 4'h0, 0, 15); prog[9]    = 16'h0008;
            prog[64]   = ins(0, 1, 4'h6, 0, 1);  prog[65]   = 16'h0200;
            prog[66]   = ins(0, 1, 4'h0, 0, 15); prog[67]   = 16'h0042;
            go(40);
            check($sformatf("cmp%0d_jmp", v), memv(16'h200),
                  (v == 5) ? 16'h0005 : 16'h0000);
            check($sformatf("cmp%0d_fall", v), memv(16'h201),
                  (v == 6) ? 16'h0006 : 16'h0000);
            check($sformatf("cmp%0d_wr", v), 16'(wr_cnt), 16'd1);
        end

        // ror into carry, bswp
        begin_prog();
        prog[0]  = ins(0, 1, 4'h0, 0, 4);  prog[1]  = 16'h0001;
        prog[2]  = ins(0, 0, 4'h8, 4, 4);
        prog[3]  = ins(0, 0, 4'hF, 0, 5);
        prog[4]  = ins(0, 1, 4'h0, 0, 6);  prog[5]  = 16'h12AB;
        prog[6]  = ins(0, 0, 4'hE, 6, 7);
        prog[7]  = ins(0, 1, 4'h6, 0, 4);  prog[8]  = 16'h0200;
        prog[9]  = ins(0, 1, 4'h6, 0, 5);  prog[10] = 16'h0201;
        prog[11] = ins(0, 1, 4'h6, 0, 7);  prog[12] = 16'h0202;
        prog[13] = ins(0, 1, 4'h0, 0, 15); prog[14] = 16'h000D;
        go(60);
        check("ror_r4", memv(16'h200), 16'h0000);
        check("ror_flags", memv(16'h201), 16'h0006);
        check("bswp_r7", memv(16'h202), 16'hAB12);

        // reset asserted while in WRMEM aborts the store
        begin_prog();
        prog[0] = ins(0, 1, 4'h0, 0, 1);  prog[1] = 16'h5555;
        prog[2] = ins(0, 1, 4'h6, 0, 1);  prog[3] = 16'h0300;
        prog[4] = ins(0, 1, 4'h0, 0, 15); prog[5] = 16'h0004;
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b0;
        clr     = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (!rnw) found = 1'b1;
        end
        check("wrmem_seen", 16'(found), 16'h1);
        reset_b = 1'b1;
        #1;
        check("abort_rnw", 16'(rnw), 16'h1);
        @(posedge clk);
        #1;
        reset_b = 1'b0;
        @(negedge clk);
        check("abort_pc", address, 16'h0000);
        check("abort_nowr", memv(16'h300), 16'h0000);
        check("abort_cnt", 16'(wr_cnt), 16'd0);
        @(posedge clk);
        #1;
        check("abort_fetch1", address, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
